// File: rtl/de2_uart_if.sv
// Core-side handshake bundle for de2_uart: valid/ready transmit path and a
// single-entry receive holding register with acknowledge and status flags.
interface de2_uart_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ack;
  logic       rx_framing_error;
  logic       rx_overrun;
  logic       rx_overrun_clear;

  // Bus master (picorisc peripheral side) drives requests and acknowledges.
  modport master (
    output tx_valid, tx_data, rx_ack, rx_overrun_clear,
    input  tx_ready, rx_valid, rx_data, rx_framing_error, rx_overrun
  );

  // UART block answers with readiness, received data and status.
  modport slave (
    input  tx_valid, tx_data, rx_ack, rx_overrun_clear,
    output tx_ready, rx_valid, rx_data, rx_framing_error, rx_overrun
  );
endinterface

// File: rtl/de2_uart.sv
// 8N1 UART for the DE2 board pins. Bit timing comes from a down-counter
// clocked by clk (BAUD_DIV cycles per bit); the receiver samples each bit
// near its centre by starting with a half-bit delay after the start edge.
module de2_uart #(
  parameter int BAUD_DIV = 434,
  parameter int USE_FLOW = 1
) (
  input  logic          clk,
  input  logic          reset,
  de2_uart_if.slave     bus,
  input  logic          de2_uart_in__rxd,
  input  logic          de2_uart_in__rts,
  output logic          de2_uart_out__txd,
  output logic          de2_uart_out__cts
);

  localparam logic [15:0] BIT_RELOAD  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Both asynchronous pins get an identical 2-flop synchroniser idling high.
  logic [1:0] sync_in;
  logic [1:0] sync_out;
  assign sync_in = {de2_uart_in__rts, de2_uart_in__rxd};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      // Two-stage metastability filter, reset to the idle-high level.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= sync_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  logic rxd_s;
  logic rts_s;
  logic flow_ok;
  assign rxd_s   = sync_out[0];
  assign rts_s   = sync_out[1];
  // Peer permission is only consulted while the transmitter is idle.
  assign flow_ok = (USE_FLOW == 0) || !rts_s;

  // ---------------------------------------------------------------- transmit
  state_t      tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_idx_reg;
  logic [7:0]  tx_shift_reg;
  logic        txd_reg;
  logic        tx_ready_reg;

  // TX FSM: start bit, 8 data bits LSB first, stop bit; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_idx_reg   <= 3'd0;
      tx_shift_reg <= 8'd0;
      txd_reg      <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else begin
      case (tx_state_reg)
        IDLE: begin
          if (bus.tx_valid && tx_ready_reg) begin
            tx_shift_reg <= bus.tx_data;
            tx_state_reg <= START;
            txd_reg      <= 1'b0;
            tx_cnt_reg   <= BIT_RELOAD;
            tx_ready_reg <= 1'b0;
          end else begin
            tx_ready_reg <= flow_ok;
          end
        end
        START: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_state_reg <= DATA;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_idx_reg   <= 3'd0;
            tx_cnt_reg   <= BIT_RELOAD;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        DATA: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_cnt_reg <= BIT_RELOAD;
            tx_idx_reg <= tx_idx_reg + 3'd1;
            if (tx_idx_reg == 3'd7) begin
              tx_state_reg <= STOP;
              txd_reg      <= 1'b1;
            end else begin
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        STOP: begin
          if (tx_cnt_reg == 16'd0) begin
            tx_state_reg <= IDLE;
            tx_ready_reg <= flow_ok;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: tx_state_reg <= IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  state_t      rx_state_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_idx_reg;
  logic [7:0]  rx_shift_reg;
  logic        rxd_prev_reg;
  logic        rx_valid_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_fe_reg;
  logic        rx_overrun_reg;

  // RX FSM plus holding register; later assignments override earlier ones so
  // a completing byte beats an ack, and a new overrun beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg   <= IDLE;
      rx_cnt_reg     <= 16'd0;
      rx_idx_reg     <= 3'd0;
      rx_shift_reg   <= 8'd0;
      rxd_prev_reg   <= 1'b1;
      rx_valid_reg   <= 1'b0;
      rx_data_reg    <= 8'd0;
      rx_fe_reg      <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rxd_prev_reg <= rxd_s;
      if (bus.rx_ack && rx_valid_reg) begin
        rx_valid_reg <= 1'b0;
        rx_fe_reg    <= 1'b0;
      end
      if (bus.rx_overrun_clear) begin
        rx_overrun_reg <= 1'b0;
      end
      case (rx_state_reg)
        IDLE: begin
          // Only a genuine 1-to-0 edge starts a frame, so a held break
          // line does not retrigger.
          if (rxd_prev_reg && !rxd_s) begin
            rx_state_reg <= START;
            rx_cnt_reg   <= HALF_RELOAD;
          end
        end
        START: begin
          if (rx_cnt_reg == 16'd0) begin
            if (rxd_s) begin
              rx_state_reg <= IDLE;
            end else begin
              rx_state_reg <= DATA;
              rx_idx_reg   <= 3'd0;
              rx_cnt_reg   <= BIT_RELOAD;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        DATA: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_shift_reg <= {rxd_s, rx_shift_reg[7:1]};
            rx_idx_reg   <= rx_idx_reg + 3'd1;
            rx_cnt_reg   <= BIT_RELOAD;
            if (rx_idx_reg == 3'd7) begin
              rx_state_reg <= STOP;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        STOP: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_state_reg <= IDLE;
            if (!rx_valid_reg || bus.rx_ack) begin
              rx_data_reg  <= rx_shift_reg;
              rx_valid_reg <= 1'b1;
              rx_fe_reg    <= !rxd_s;
            end else begin
              rx_overrun_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        default: rx_state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready         = tx_ready_reg;
  assign bus.rx_valid         = rx_valid_reg;
  assign bus.rx_data          = rx_data_reg;
  assign bus.rx_framing_error = rx_fe_reg;
  assign bus.rx_overrun       = rx_overrun_reg;
  assign de2_uart_out__txd    = txd_reg;
  // Ask the peer to pause whenever the holding register is occupied.
  assign de2_uart_out__cts    = rx_valid_reg;

endmodule

// File: tb/tb_de2_uart.sv
// Directed testbench for de2_uart at BAUD_DIV=8 with flow control enabled.
module tb_de2_uart;
  localparam int BAUD_DIV = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  logic rts   = 1'b0;
  logic txd;
  logic cts;

  de2_uart_if bus();

  de2_uart #(.BAUD_DIV(BAUD_DIV), .USE_FLOW(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .de2_uart_in__rxd  (rxd),
    .de2_uart_in__rts  (rts),
    .de2_uart_out__txd (txd),
    .de2_uart_out__cts (cts)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Drive one serial frame on rxd, each bit held BAUD_DIV cycles.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = frame_of(d, stop);
    for (int b = 0; b < 10; b++) begin
      rxd = f[b];
      repeat (BAUD_DIV) tick();
    end
    rxd = 1'b1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_txd"},      txd, 1);
    check({pfx, "_tx_ready"}, bus.tx_ready, 1);
    check({pfx, "_rx_valid"}, bus.rx_valid, 0);
    check({pfx, "_rx_data"},  bus.rx_data, 0);
    check({pfx, "_fe"},       bus.rx_framing_error, 0);
    check({pfx, "_overrun"},  bus.rx_overrun, 0);
    check({pfx, "_cts"},      cts, 0);
  endtask

  initial begin
    logic [9:0] f1;
    logic [9:0] f2;
    logic       exp_bit;
    int         m1;
    int         m2;

    bus.tx_valid         = 1'b0;
    bus.tx_data          = 8'h00;
    bus.rx_ack           = 1'b0;
    bus.rx_overrun_clear = 1'b0;

    // Reset state
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b0;
    repeat (5) tick();
    $display("[TB] reset released");

    // Single byte 0xA5
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    tick();
    bus.tx_valid = 1'b0;
    check("tx_ready_drop", bus.tx_ready, 0);
    check("tx_start_bit", txd, 0);
    f1 = frame_of(8'hA5, 1'b1);
    for (int b = 0; b < 10; b++) begin
      m1 = 0;
      for (int c = 0; c < BAUD_DIV; c++) begin
        if (txd === f1[b]) m1++;
        if (b == 9 && c == BAUD_DIV - 1) check("tx_ready_busy", bus.tx_ready, 0);
        tick();
      end
      check($sformatf("tx_a5_bit%0d", b), m1, BAUD_DIV);
    end
    check("tx_ready_back", bus.tx_ready, 1);
    check("tx_idle_txd", txd, 1);
    $display("[TB] tx 0xa5 frame");

    // Back-to-back 0x55 then 0x0F
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h55;
    tick();
    bus.tx_data = 8'h0F;
    f1 = frame_of(8'h55, 1'b1);
    f2 = frame_of(8'h0F, 1'b1);
    m1 = 0;
    m2 = 0;
    for (int k = 0; k <= 160; k++) begin
      if (k < 80)       exp_bit = f1[k / 8];
      else if (k == 80) exp_bit = 1'b1;
      else              exp_bit = f2[(k - 81) / 8];
      if (k <= 80) begin
        if (txd === exp_bit) m1++;
      end else begin
        if (txd === exp_bit) m2++;
      end
      if (k == 80) check("b2b_ready_gap", bus.tx_ready, 1);
      if (k == 81) begin
        check("b2b_start2_at_81", txd, 0);
        bus.tx_valid = 1'b0;
      end
      tick();
    end
    check("b2b_frame1", m1, 81);
    check("b2b_frame2", m2, 80);
    $display("[TB] tx 0x55,0x0f back-to-back");

    // Flow control: rts high blocks the transmitter
    rts = 1'b1;
    repeat (4) tick();
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    m1 = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.tx_ready === 1'b0 && txd === 1'b1) m1++;
      tick();
    end
    check("flow_hold", m1, 100);
    bus.tx_valid = 1'b0;
    rts = 1'b0;
    tick();
    check("rts_lat1", bus.tx_ready, 0);
    tick();
    check("rts_lat2", bus.tx_ready, 0);
    tick();
    check("rts_lat3", bus.tx_ready, 1);
    $display("[TB] flow control rts");

    // Receive 0x3C
    check("cts_idle", cts, 0);
    send_byte(8'h3C, 1'b1);
    repeat (2) tick();
    check("rx3c_valid", bus.rx_valid, 1);
    check("rx3c_data", bus.rx_data, 8'h3C);
    check("rx3c_fe", bus.rx_framing_error, 0);
    check("rx3c_cts", cts, 1);
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    check("rx3c_ack_valid", bus.rx_valid, 0);
    check("rx3c_ack_cts", cts, 0);
    $display("[TB] rx 0x3c");

    // Framing error on 0x81, then a short glitch
    send_byte(8'h81, 1'b0);
    repeat (2) tick();
    check("rx81_valid", bus.rx_valid, 1);
    check("rx81_data", bus.rx_data, 8'h81);
    check("rx81_fe", bus.rx_framing_error, 1);
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    check("rx81_ack_fe", bus.rx_framing_error, 0);
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (30) tick();
    check("glitch_no_valid", bus.rx_valid, 0);
    $display("[TB] rx 0x81 framing error, glitch");

    // Overrun
    send_byte(8'h11, 1'b1);
    repeat (2) tick();
    check("ovr_first_data", bus.rx_data, 8'h11);
    check("ovr_no_flag_yet", bus.rx_overrun, 0);
    send_byte(8'h22, 1'b1);
    repeat (2) tick();
    check("ovr_data_kept", bus.rx_data, 8'h11);
    check("ovr_valid_kept", bus.rx_valid, 1);
    check("ovr_flag", bus.rx_overrun, 1);
    bus.rx_overrun_clear = 1'b1;
    tick();
    bus.rx_overrun_clear = 1'b0;
    check("ovr_cleared", bus.rx_overrun, 0);
    $display("[TB] rx overrun 0x11/0x22");

    // Reset mid-frame on both directions
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    tick();
    bus.tx_valid = 1'b0;
    rxd = 1'b0;
    repeat (20) tick();
    check("pre_reset_txd", txd, 0);
    check("pre_reset_cts", cts, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (3) tick();
    rxd = 1'b1;
    reset = 1'b0;
    repeat (100) tick();
    check("post_reset_rx_idle", bus.rx_valid, 0);
    check("post_reset_txd", txd, 1);
    $display("[TB] reset mid-frame");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/de2_uart.md
Name: de2_uart

Overview:
- 8N1 UART serialiser/deserialiser feeding the DE2 board-level UART pins: drives de2_uart_out__txd/cts and consumes de2_uart_in__rxd/rts.
- Sits between the picorisc peripheral bus and the board top.
- Core side uses a valid/ready transmit handshake and a single-entry receive holding register with acknowledge, framing-error and overrun flags.
- Baud timing comes from a parameterised clock divider; there is no separate baud clock.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- USE_FLOW, 1, when 1 the transmitter honours the RTS input (rts_n low = peer may receive).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- tx_valid  in  1  transmit byte offered
- tx_data  in  8  transmit byte
- tx_ready  out  1  block can accept a byte this cycle
- rx_valid  out  1  received byte held
- rx_data  out  8  received byte
- rx_ack  in  1  consumer takes held byte
- rx_framing_error  out  1  stop bit of the held byte was sampled low
- rx_overrun  out  1  a byte was lost because the holding register was full; sticky
- rx_overrun_clear  in  1  clears rx_overrun
- de2_uart_in__rxd  in  1  serial input, idle high
- de2_uart_in__rts  in  1  peer flow control, active low
- de2_uart_out__txd  out  1  serial output, idle high
- de2_uart_out__cts  out  1  our flow control, active low

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All state is cleared immediately on reset assertion.
- Reset values: txd=1, tx_ready=1, rx_valid=0, rx_data=0, rx_framing_error=0, rx_overrun=0, cts=0.
- cts: cts = rx_valid (1 while the holding register is occupied, i.e. asking the peer to pause).
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx_ready=1 iff (USE_FLOW==0 or rts==0). A transfer on tx_valid&tx_ready latches tx_data; the next cycle enters START with txd=0.
  - Bit timing: each bit is held exactly BAUD_DIV cycles by a 16-bit down-counter reloaded to BAUD_DIV-1 at each bit boundary.
  - DATA: shifts LSB first for 8 bits, using a 3-bit index that wraps from 7 into STOP.
  - STOP: txd=1 for BAUD_DIV cycles, then IDLE.
  - tx_ready=0 in all states other than IDLE.
  - Back-to-back: a byte accepted in the first IDLE cycle starts immediately, giving a 10*BAUD_DIV+1 cycle frame period.
  - An rts change mid-frame has no effect; it is sampled only in IDLE.
- RX input:
  - rxd passes through a 2-flop synchroniser (reset value 1) before use.
  - rts is also 2-flop synchronised (reset value 1); tx_ready therefore uses the synchronised rts.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronised falling edge (1 then 0) enters START and loads the counter with BAUD_DIV/2-1 (integer divide).
  - START: at counter 0, if rxd=1 the start is treated as a glitch and the FSM returns to IDLE with no output. Otherwise the counter reloads BAUD_DIV-1 and the FSM enters DATA.
  - DATA: samples 8 bits, one every BAUD_DIV cycles at counter 0, LSB first into a shift register.
  - STOP: samples the stop bit at counter 0, then completes the byte.
- Byte completion, same cycle as the stop sample:
  - If rx_valid=0 (or rx_ack is asserted this cycle): load rx_data and set rx_valid=1, rx_framing_error = ~stop_sample.
  - Otherwise: drop the byte, set rx_overrun=1, leave the held data unchanged.
  - The FSM returns to IDLE; a new start edge may then be detected on the next cycle.
- rx_ack:
  - rx_ack with rx_valid=1 clears rx_valid and rx_framing_error next cycle, unless a completion loads a new byte in the same cycle, in which case the new byte wins.
  - rx_ack with rx_valid=0 is ignored.
- rx_overrun_clear: clears rx_overrun. If it is asserted in the same cycle as a new overrun, the set wins.
- Break (rxd held low): produces byte 0x00 with framing_error=1. The RX FSM then stays in IDLE until rxd returns high, since only a new 1-to-0 edge restarts it.
- Reset mid-frame: both FSMs return to IDLE at once, txd=1, and any partial byte is discarded.

Test Plan (BAUD_DIV=8 unless stated):
- Reset then tx_valid with tx_data=0xA5 -> tx_ready drops the next cycle; txd shows 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; tx_ready=1 after 81 cycles.
- Two bytes 0x55 then 0x0F offered back-to-back -> the second start bit begins exactly 81 cycles after the first acceptance, with no idle gap beyond one cycle.
- USE_FLOW=1 with rts=1 -> tx_ready stays 0 and txd stays 1 for 100 cycles. Drop rts -> tx_ready=1 three cycles later (synchroniser delay plus register).
- Drive serial 0x3C with a correct stop bit on rxd -> rx_valid=1 with rx_data=0x3C, framing_error=0, cts=0→1. Then rx_ack -> rx_valid=0 and cts=0.
- Send 0x81 with the stop bit low -> rx_data=0x81 and rx_framing_error=1. Send a 2-cycle low glitch -> no rx_valid.
- Receive 0x11 without ack, then 0x22 -> rx_data stays 0x11 and rx_overrun=1. Assert rx_overrun_clear -> rx_overrun=0. Assert reset mid-byte -> all outputs return to reset values immediately.
